// File: rtl/diamond_pkg.sv
// Shared types and the player/gem overlap test for the gem manager.
package diamond_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       present;
        logic       collected;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Strict box overlap on the un-bobbed gem; sums widened to 11 bits so edges near 1023 do not wrap.
    function automatic logic overlap(
        input logic [9:0]  px,
        input logic [9:0]  py,
        input logic [9:0]  gx,
        input logic [9:0]  gy,
        input logic [10:0] size,
        input logic [10:0] pw,
        input logic [10:0] ph
    );
        logic [10:0] px_w, py_w, gx_w, gy_w;
        px_w = {1'b0, px};
        py_w = {1'b0, py};
        gx_w = {1'b0, gx};
        gy_w = {1'b0, gy};
        return (px_w < gx_w + size) && (gx_w < px_w + pw) &&
               (py_w < gy_w + size) && (gy_w < py_w + ph);
    endfunction

endpackage

// File: rtl/diamond_slot_hit.sv
// Combinational draw test for one gem slot: hit flag plus sprite ROM offset.
module diamond_slot_hit
    import diamond_pkg::*;
#(
    parameter int SIZE   = 20,
    parameter int ADDR_W = 9
) (
    input  slot_t              slot,
    input  logic [9:0]         bob,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    output logic               hit,
    output logic [ADDR_W-1:0]  offset
);

    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic [10:0] dx, dy, col, row;

    always_comb begin
        x_lo = {1'b0, slot.x};
        x_hi = x_lo + 11'(SIZE);
        y_lo = {1'b0, slot.y} + {1'b0, bob};
        y_hi = y_lo + 11'(SIZE);
        dx   = {1'b0, draw_x};
        dy   = {1'b0, draw_y};
        hit  = slot.present && !slot.collected &&
               (dx >= x_lo) && (dx < x_hi) &&
               (dy >= y_lo) && (dy < y_hi);
        // Only meaningful when hit; the top zeroes the address otherwise.
        col    = dx - x_lo;
        row    = dy - y_lo;
        offset = ADDR_W'(col) + ADDR_W'(row) * ADDR_W'(SIZE);
    end

endmodule

// File: rtl/diamond_field.sv
// Collectible-gem manager for one colour: loadable slots, registered draw path,
// per-frame player overlap scan and bob animation.
module diamond_field
    import diamond_pkg::*;
#(
    parameter int N_DIAM     = 3,
    parameter int SIZE       = 20,
    parameter int ADDR_W     = 9,
    parameter int PLAYER_W   = 24,
    parameter int PLAYER_H   = 32,
    parameter int BOB_PERIOD = 32,
    parameter int BOB_AMP    = 2,
    localparam int IDX_W     = (N_DIAM > 1) ? $clog2(N_DIAM) : 1,
    localparam int CNT_W     = $clog2(N_DIAM + 1)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              level_start,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [9:0]        load_x,
    input  logic [9:0]        load_y,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_diamond,
    output logic [ADDR_W-1:0] diamond_address,
    output logic [IDX_W-1:0]  diamond_id,
    output logic              collect_pulse,
    output logic [IDX_W-1:0]  collect_id,
    output logic [CNT_W-1:0]  collected_count,
    output logic              all_collected,
    output logic              scan_busy
);

    localparam int PH_W = $clog2(BOB_PERIOD);
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_DIAM);

    slot_t               slots [N_DIAM];
    scan_state_t         state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [9:0]          px_l, py_l;
    logic [PH_W-1:0]     phase;
    logic [9:0]          bob;
    logic                latch_player;
    logic                scan_hit;
    logic                load_ok;

    logic [N_DIAM-1:0]   hits;
    logic [ADDR_W-1:0]   offsets [N_DIAM];
    logic                hit_any;
    logic [IDX_W-1:0]    hit_id;
    logic [ADDR_W-1:0]   hit_addr;
    logic [N_DIAM-1:0]   present_mask, pending_mask;

    assign bob       = (phase < PH_W'(BOB_PERIOD / 2)) ? 10'd0 : 10'(BOB_AMP);
    assign load_ok   = load_en && ({1'b0, load_idx} < N_LIM);
    assign scan_busy = (state != IDLE);

    for (genvar g = 0; g < N_DIAM; g++) begin : g_slot
        diamond_slot_hit #(
            .SIZE   (SIZE),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .slot   (slots[g]),
            .bob    (bob),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hits[g]),
            .offset (offsets[g])
        );
    end

    // Lowest index wins: walk downwards so the last assignment is the lowest hit.
    always_comb begin
        hit_any  = 1'b0;
        hit_id   = '0;
        hit_addr = '0;
        for (int k = N_DIAM - 1; k >= 0; k--) begin
            if (hits[k]) begin
                hit_any  = 1'b1;
                hit_id   = IDX_W'(k);
                hit_addr = offsets[k];
            end
        end
    end

    always_comb begin
        present_mask = '0;
        pending_mask = '0;
        for (int k = 0; k < N_DIAM; k++) begin
            present_mask[k] = slots[k].present;
            pending_mask[k] = slots[k].present && !slots[k].collected;
        end
        all_collected = (present_mask != '0) && (pending_mask == '0);
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        latch_player = 1'b0;
        scan_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_next   = SCAN;
                    idx_next     = '0;
                    latch_player = 1'b1;
                end
            end
            SCAN: begin
                // A load to the slot under test in the same cycle takes precedence.
                scan_hit = slots[idx].present && !slots[idx].collected &&
                           overlap(px_l, py_l, slots[idx].x, slots[idx].y,
                                   11'(SIZE), 11'(PLAYER_W), 11'(PLAYER_H)) &&
                           !(load_en && (load_idx == idx));
                if (idx == IDX_W'(N_DIAM - 1)) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (level_start) begin
            state_next   = IDLE;
            latch_player = 1'b0;
            scan_hit     = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int k = 0; k < N_DIAM; k++) begin
                slots[k] <= '0;
            end
            state           <= IDLE;
            idx             <= '0;
            px_l            <= '0;
            py_l            <= '0;
            phase           <= '0;
            is_diamond      <= 1'b0;
            diamond_address <= '0;
            diamond_id      <= '0;
            collect_pulse   <= 1'b0;
            collect_id      <= '0;
            collected_count <= '0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            is_diamond      <= hit_any;
            diamond_address <= hit_addr;
            diamond_id      <= hit_id;
            collect_pulse   <= scan_hit;
            if (latch_player) begin
                px_l <= player_x;
                py_l <= player_y;
            end
            if (level_start) begin
                for (int k = 0; k < N_DIAM; k++) begin
                    slots[k].collected <= 1'b0;
                end
                collected_count <= '0;
                phase           <= '0;
            end else begin
                if (scan_hit) begin
                    slots[idx].collected <= 1'b1;
                    collect_id           <= idx;
                    if (collected_count < CNT_W'(N_DIAM)) begin
                        collected_count <= collected_count + 1'b1;
                    end
                end
                if (frame_tick) begin
                    phase <= (phase == PH_W'(BOB_PERIOD - 1)) ? '0 : phase + 1'b1;
                end
            end
            for (int k = 0; k < N_DIAM; k++) begin
                if (load_ok && (load_idx == IDX_W'(k))) begin
                    slots[k] <= '{x: load_x, y: load_y, present: 1'b1, collected: 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_diamond_field.sv
// Self-checking bench for diamond_field: directed scenarios plus randomized traffic
// against a behavioural model of slots, scan timing and bob phase.
module tb_diamond_field;

    localparam int N          = 3;
    localparam int SIZE       = 20;
    localparam int ADDR_W     = 9;
    localparam int PLAYER_W   = 24;
    localparam int PLAYER_H   = 32;
    localparam int BOB_PERIOD = 32;
    localparam int BOB_AMP    = 2;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              frame_tick, level_start, load_en;
    logic [1:0]        load_idx;
    logic [9:0]        load_x, load_y, player_x, player_y, DrawX, DrawY;
    logic              is_diamond;
    logic [ADDR_W-1:0] diamond_address;
    logic [1:0]        diamond_id;
    logic              collect_pulse;
    logic [1:0]        collect_id;
    logic [1:0]        collected_count;
    logic              all_collected;
    logic              scan_busy;

    int errors = 0;
    int checks = 0;

    // Model state.
    int mx [N];
    int my [N];
    bit mpres [N];
    bit mcoll [N];
    int mcount, mphase, age, lpx, lpy;
    int e_is, e_addr, e_id, e_pulse, e_cid;

    diamond_field #(
        .N_DIAM     (N),
        .SIZE       (SIZE),
        .ADDR_W     (ADDR_W),
        .PLAYER_W   (PLAYER_W),
        .PLAYER_H   (PLAYER_H),
        .BOB_PERIOD (BOB_PERIOD),
        .BOB_AMP    (BOB_AMP)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_tick      (frame_tick),
        .level_start     (level_start),
        .load_en         (load_en),
        .load_idx        (load_idx),
        .load_x          (load_x),
        .load_y          (load_y),
        .player_x        (player_x),
        .player_y        (player_y),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .is_diamond      (is_diamond),
        .diamond_address (diamond_address),
        .diamond_id      (diamond_id),
        .collect_pulse   (collect_pulse),
        .collect_id      (collect_id),
        .collected_count (collected_count),
        .all_collected   (all_collected),
        .scan_busy       (scan_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic bit model_all();
        bit any_p = 0;
        bit all_c = 1;
        for (int k = 0; k < N; k++) begin
            if (mpres[k]) begin
                any_p = 1;
                if (!mcoll[k]) all_c = 0;
            end
        end
        return any_p && all_c;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int bob, gy;
        bit found;
        if (!Reset_n) begin
            for (int k = 0; k < N; k++) begin
                mx[k] = 0; my[k] = 0; mpres[k] = 0; mcoll[k] = 0;
            end
            mcount = 0; mphase = 0; age = -1; lpx = 0; lpy = 0;
            e_is = 0; e_addr = 0; e_id = 0; e_pulse = 0; e_cid = 0;
            return;
        end
        bob = (mphase < BOB_PERIOD / 2) ? 0 : BOB_AMP;
        e_is = 0; e_addr = 0; e_id = 0; found = 0;
        for (int k = 0; k < N; k++) begin
            gy = my[k] + bob;
            if (!found && mpres[k] && !mcoll[k] &&
                int'(DrawX) >= mx[k] && int'(DrawX) < mx[k] + SIZE &&
                int'(DrawY) >= gy && int'(DrawY) < gy + SIZE) begin
                found  = 1;
                e_is   = 1;
                e_id   = k;
                e_addr = (int'(DrawX) - mx[k]) + (int'(DrawY) - gy) * SIZE;
            end
        end
        e_pulse = 0;
        if (level_start) begin
            for (int k = 0; k < N; k++) mcoll[k] = 0;
            mcount = 0; mphase = 0; age = -1;
        end else begin
            if (age >= 0) begin
                if (age < N) begin
                    if (mpres[age] && !mcoll[age] &&
                        lpx < mx[age] + SIZE && mx[age] < lpx + PLAYER_W &&
                        lpy < my[age] + SIZE && my[age] < lpy + PLAYER_H &&
                        !(load_en && int'(load_idx) == age)) begin
                        mcoll[age] = 1;
                        e_pulse = 1;
                        e_cid = age;
                        if (mcount < N) mcount++;
                    end
                end
                age++;
                if (age > N) age = -1;
            end else if (frame_tick) begin
                age = 0; lpx = player_x; lpy = player_y;
            end
            if (frame_tick) mphase = (mphase + 1) % BOB_PERIOD;
        end
        if (load_en && int'(load_idx) < N) begin
            mx[load_idx] = load_x; my[load_idx] = load_y;
            mpres[load_idx] = 1; mcoll[load_idx] = 0;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_eq("is_diamond", is_diamond, e_is);
        check_eq("address", diamond_address, e_addr);
        check_eq("diamond_id", diamond_id, e_id);
        check_eq("collect_pulse", collect_pulse, e_pulse);
        check_eq("collect_id", collect_id, e_cid);
        check_eq("count", collected_count, mcount);
        check_eq("all_collected", all_collected, model_all());
        check_eq("scan_busy", scan_busy, age >= 0);
    endtask

    task automatic load(input int idx, input int x, input int y);
        load_en = 1; load_idx = 2'(idx); load_x = 10'(x); load_y = 10'(y);
        step();
        load_en = 0;
    endtask

    task automatic tick_scan(input int px, input int py);
        player_x = 10'(px); player_y = 10'(py);
        frame_tick = 1;
        step();
        frame_tick = 0;
        repeat (N + 2) step();
    endtask

    task automatic pixel(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
    endtask

    initial begin
        int k;
        Reset_n = 0; frame_tick = 0; level_start = 0; load_en = 0; load_idx = 0;
        load_x = 0; load_y = 0; player_x = 0; player_y = 0; DrawX = 0; DrawY = 0;
        step(); step();
        check_eq("rst_busy", scan_busy, 0);
        check_eq("rst_count", collected_count, 0);
        Reset_n = 1;

        load(0, 460, 408); load(1, 366, 238); load(2, 38, 90);
        pixel(465, 413);
        check_eq("tp_hit", is_diamond, 1);
        check_eq("tp_addr", diamond_address, 105);
        check_eq("tp_id", diamond_id, 0);
        pixel(459, 408);
        check_eq("tp_left_miss", is_diamond, 0);

        DrawX = 465; DrawY = 413;
        player_x = 450; player_y = 400; frame_tick = 1;
        step();
        frame_tick = 0;
        check_eq("tp_busy", scan_busy, 1);
        step();
        check_eq("tp_pulse", collect_pulse, 1);
        check_eq("tp_cid", collect_id, 0);
        check_eq("tp_count1", collected_count, 1);
        repeat (4) step();
        check_eq("tp_gone", is_diamond, 0);
        tick_scan(450, 400);
        check_eq("tp_no_recollect", collected_count, 1);
        tick_scan(370, 240);
        tick_scan(40, 92);
        check_eq("tp_count3", collected_count, 3);
        check_eq("tp_all", all_collected, 1);

        load(0, 100, 100); load(1, 100, 100);
        pixel(105, 105);
        check_eq("prio_id0", diamond_id, 0);
        load(1, 600, 600);
        tick_scan(90, 90);
        load(1, 100, 100);
        pixel(105, 105);
        check_eq("prio_hit", is_diamond, 1);
        check_eq("prio_id1", diamond_id, 1);

        level_start = 1; step(); level_start = 0;
        load(0, 460, 408);
        player_x = 900; player_y = 900;
        repeat (16) begin
            frame_tick = 1; step(); frame_tick = 0; step();
        end
        repeat (N + 2) step();
        pixel(465, 428);
        check_eq("bob_hit", is_diamond, 1);
        check_eq("bob_addr", diamond_address, 365);
        pixel(465, 408);
        check_eq("bob_top_miss", is_diamond, 0);
        pixel(465, 410);
        check_eq("bob_row0_addr", diamond_address, 5);

        frame_tick = 1; step(); frame_tick = 0; step();
        frame_tick = 1; step(); frame_tick = 0;
        step(); step();
        check_eq("tick_ignored", scan_busy, 0);

        player_x = 455; player_y = 400;
        frame_tick = 1; step(); frame_tick = 0; step();
        check_eq("ls_pre_count", collected_count, 1);
        level_start = 1; step(); level_start = 0;
        check_eq("ls_busy", scan_busy, 0);
        check_eq("ls_count", collected_count, 0);

        frame_tick = 1; step(); frame_tick = 0; step();
        Reset_n = 0; step();
        check_eq("rst_mid_pulse", collect_pulse, 0);
        check_eq("rst_mid_busy", scan_busy, 0);
        check_eq("rst_mid_count", collected_count, 0);
        check_eq("rst_mid_is", is_diamond, 0);
        Reset_n = 1;

        for (int c = 0; c < 4000; c++) begin
            Reset_n     = ($urandom_range(0, 599) != 0);
            level_start = ($urandom_range(0, 79) == 0);
            frame_tick  = ($urandom_range(0, 5) == 0);
            load_en     = ($urandom_range(0, 9) == 0);
            load_idx    = 2'($urandom_range(0, 3));
            load_x      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 200));
            load_y      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 200));
            k = $urandom_range(0, N - 1);
            player_x    = 10'(clamp10(mx[k] + $urandom_range(0, 60) - 30));
            player_y    = 10'(clamp10(my[k] + $urandom_range(0, 70) - 35));
            k = $urandom_range(0, N - 1);
            DrawX       = 10'(clamp10(mx[k] + $urandom_range(0, SIZE + 5) - 3));
            DrawY       = 10'(clamp10(my[k] + $urandom_range(0, SIZE + 8) - 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
